fetch_stage: RTL and testbench

Instruction fetch stage for the WISC-SP22 datapath: owns the 16-bit PC, issues single-outstanding requests to instruction memory, and holds the returned instruction until decode accepts it. Its `if_instr[15:11]`/`[1:0]` drive the control unit's OpCode/funct inputs. Decode/execute feed back `redirect`/`redirect_pc` for taken branches and jumps, and a `halt` indication for HALT.

---
 rtl/wisc_pkg.sv | 14 +
 rtl/fetch_hold_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC-SP22 datapath constants and fetch FSM state type
package wisc_pkg;

  localparam int              DATA_W   = 16;
  localparam logic [DATA_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_reg.sv
// rtl/fetch_hold_reg.sv - one-entry holding register for the fetched instruction and its PCs
module fetch_hold_reg #(
  parameter int W = wisc_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] instr_i,
  input  logic [W-1:0] pc_i,
  output logic         valid_o,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_plus2_o
);

  logic         valid_q;
  logic [W-1:0] instr_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] pc_plus2_q;

  // Load captures a new entry; clear only drops valid so the data lines stay quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus2_q <= '0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus2_q <= pc_i + W'(2);
    end else if (clear_i) begin
      valid_q    <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_plus2_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - WISC-SP22 instruction fetch stage; FETCH_ALIGN_CHK_EN enables odd-redirect trapping
module fetch_stage #(
  parameter int                DATA_W   = wisc_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = wisc_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_pc_plus2,
  input  logic              id_ready,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted,
  output logic              err
);

  import wisc_pkg::*;

`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              squash_q, squash_d;
  logic              err_q, err_d;

  logic              req;
  logic              hold_load;
  logic              hold_clear;
  logic              redir_odd;
  logic [DATA_W-1:0] redir_target;

  // An odd target is trapped when checking is on; otherwise bit 0 is simply dropped.
  assign redir_odd    = ALIGN_CHK && redirect_pc[0];
  assign redir_target = {redirect_pc[DATA_W-1:1], 1'b0};

  // Next-state logic: halt acceptance beats redirect, which beats normal flow.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    squash_d   = squash_q;
    err_d      = err_q;
    req        = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          if (redir_odd) begin
            err_d   = 1'b1;
            state_d = HALTED;
          end else begin
            pc_d = redir_target;
          end
        end else begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          if (redir_odd) begin
            err_d    = 1'b1;
            squash_d = 1'b0;
            state_d  = HALTED;
          end else begin
            pc_d = redir_target;
            if (imem_ack) begin
              // The arriving word belongs to the old stream; drop it and refetch.
              squash_d = 1'b0;
              state_d  = FETCH;
            end else begin
              // Response still in flight: stay here until it lands, then discard it.
              squash_d = 1'b1;
            end
          end
        end else if (imem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            hold_load = 1'b1;
            pc_d      = pc_q + DATA_W'(2);
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (id_ready && halt) begin
          hold_clear = 1'b1;
          state_d    = HALTED;
        end else if (redirect) begin
          hold_clear = 1'b1;
          if (redir_odd) begin
            err_d   = 1'b1;
            state_d = HALTED;
          end else begin
            pc_d    = redir_target;
            state_d = FETCH;
          end
        end else if (id_ready) begin
          // Hand over and request the next word in the same cycle.
          hold_clear = 1'b1;
          req        = 1'b1;
          state_d    = WAIT;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // FSM, PC, squash flag and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      err_q    <= err_d;
    end
  end

  assign imem_req  = req && !rst;
  assign imem_addr = imem_req ? pc_q : '0;
  assign halted    = (state_q == HALTED);
  assign err       = err_q;

  fetch_hold_reg #(
    .W(DATA_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hold_load),
    .clear_i    (hold_clear),
    .instr_i    (imem_data),
    .pc_i       (pc_q),
    .valid_o    (if_valid),
    .instr_o    (if_instr),
    .pc_o       (if_pc),
    .pc_plus2_o (if_pc_plus2)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_valid_cyc = 0;

  int          mem_lat = 1;
  bit          use_force = 1'b0;
  logic [15:0] force_data = 16'h0000;
  bit          pending = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = 16'h0000;
  bit          dead_seen = 1'b0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Instruction memory model with programmable latency and optional forced data.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    imem_ack <= 1'b0;
    if (rst) begin
      pending <= 1'b0;
    end else begin
      if (pending) begin
        if (pend_cnt <= 1) begin
          imem_ack  <= 1'b1;
          imem_data <= use_force ? force_data : mem_word(pend_addr);
          pending   <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
      if (imem_req) begin
        if (mem_lat <= 1) begin
          imem_ack  <= 1'b1;
          imem_data <= use_force ? force_data : mem_word(imem_addr);
        end else begin
          pending   <= 1'b1;
          pend_cnt  <= mem_lat - 1;
          pend_addr <= imem_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if_valid && if_instr == 16'hDEAD) dead_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!if_valid && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(if_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    imem_data = 16'h0000;
    id_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    halt = 1'b0;
    step();
    step();
    #1;
    check_eq("rst_outs", {imem_req, imem_addr, if_valid, halted, err},
             {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    check_eq("rst_if", {if_instr, if_pc}, 32'h0);
    check_eq("rst_plus2", 32'(if_pc_plus2), 32'h0);

    // free run with 1-cycle memory
    step();
    rst = 1'b0;
    #1;
    check_eq("first_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
    for (int i = 0; i < 2; i++) begin
      wait_valid("run");
      check_eq("run_pc", 32'(if_pc), 32'(16'(2 * i)));
      check_eq("run_instr", 32'(if_instr), 32'(mem_word(16'(2 * i))));
      check_eq("run_plus2", 32'(if_pc_plus2), 32'(16'(2 * i + 2)));
      if (i > 0) check_eq("run_spacing", 32'(cyc - last_valid_cyc), 32'd2);
      last_valid_cyc = cyc;
      step();
    end

    // backpressure at if_pc 0004
    id_ready = 1'b0;
    wait_valid("bp");
    check_eq("bp_pc", 32'(if_pc), 32'h0004);
    check_eq("bp_spacing", 32'(cyc - last_valid_cyc), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check_eq("bp_stable", {imem_req, if_valid, if_pc, 14'h0},
               {1'b0, 1'b1, 16'h0004, 14'h0});
      check_eq("bp_instr", 32'(if_instr), 32'(mem_word(16'h0004)));
    end
    mem_lat = 3;
    use_force = 1'b1;
    force_data = 16'hDEAD;
    id_ready = 1'b1;
    #1;
    check_eq("bp_release", {imem_req, imem_addr}, {1'b1, 16'h0006});

    // redirect while waiting; late 16'hDEAD response must vanish
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    check_eq("wait_noreq", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    step();
    mem_lat = 1;
    use_force = 1'b0;
    step();
    #1;
    check_eq("redir_req", {imem_req, imem_addr}, {1'b1, 16'h0040});
    wait_valid("redir");
    check_eq("redir_pc", 32'(if_pc), 32'h0040);
    check_eq("dead_dropped", 32'(dead_seen), 32'd0);

    // redirect in WAIT with same-cycle ack, then PC wrap
    step();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    #1;
    check_eq("wrap_req", {imem_req, imem_addr}, {1'b1, 16'hFFFE});
    wait_valid("wrap");
    check_eq("wrap_pc", 32'(if_pc), 32'h0000FFFE);
    check_eq("wrap_plus2", 32'(if_pc_plus2), 32'h0);
    check_eq("wrap_instr", 32'(if_instr), 32'(mem_word(16'hFFFE)));
    step();
    wait_valid("wrap2");
    check_eq("wrap2_pc", 32'(if_pc), 32'h0);

    // odd redirect from HOLD
    redirect = 1'b1;
    redirect_pc = 16'h0013;
    #1;
    check_eq("odd_noreq", 32'(imem_req), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    check_eq("odd_drop", 32'(if_valid), 32'd0);
`ifdef FETCH_ALIGN_CHK_EN
    check_eq("odd_trap", {imem_req, halted, err}, {1'b0, 1'b1, 1'b1});
    step();
    #1;
    check_eq("odd_trap_hold", {imem_req, halted, err}, {1'b0, 1'b1, 1'b1});
`else
    check_eq("odd_fetch", {imem_req, imem_addr, err}, {1'b1, 16'h0012, 1'b0});
    wait_valid("odd");
    check_eq("odd_pc", 32'(if_pc), 32'h0012);
`endif

    // reset again, then HALT with a simultaneous redirect
    rst = 1'b1;
    step();
    step();
    #1;
    check_eq("rst2", {if_valid, halted, err, imem_req}, 4'b0000);
    rst = 1'b0;
    wait_valid("h");
    check_eq("h_pc", 32'(if_pc), 32'h0);
    halt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    check_eq("h_noreq", 32'(imem_req), 32'd0);
    step();
    halt = 1'b0;
    redirect = 1'b0;
    #1;
    check_eq("halted", {halted, if_valid, imem_req, err}, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check_eq("halted_stay", {halted, imem_req}, 2'b10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
